fb_write_arbiter: RTL and testbench
===================================

# fb_write_arbiter

Multi-channel framebuffer write port for the display processor. It accepts pixel writes (x, y, value) from `NUM_CH` RISC-V cores' framebuffer ports and buffers each channel in its own FIFO. Channels are arbitrated round-robin onto a single framebuffer write bus with a valid/ready handshake, and coordinates are converted to a linear pixel address. It sits between the cores' `fb_wr_pxl_*` outputs and the framebuffer memory controller.

## Interface
Parameters:
- `NUM_CH`, 2: number of writer channels (1..8).
- `X_W`, 10: x coordinate width.
- `Y_W`, 10: y coordinate width.
- `PXL_W`, 12: pixel value width.
- `FB_WIDTH`, 640: framebuffer width in pixels.
- `FB_HEIGHT`, 480: framebuffer height in pixels.
- `FIFO_DEPTH`, 4: per-channel FIFO entries, power of 2, ≥2.
- `ADDR_W`, 19: linear address width.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `ch_pxl_x`  in  NUM_CH*X_W  per-channel x; channel i at [i*X_W +: X_W].
- `ch_pxl_y`  in  NUM_CH*Y_W  per-channel y.
- `ch_pxl_value`  in  NUM_CH*PXL_W  per-channel pixel value.
- `ch_wr_en`  in  NUM_CH  per-channel write request.
- `ch_ready`  out  NUM_CH  channel FIFO not full.
- `fb_wr_addr`  out  ADDR_W  linear address y*FB_WIDTH + x.
- `fb_wr_data`  out  PXL_W  pixel value.
- `fb_wr_ch`  out  $clog2(NUM_CH) (min 1)  source channel of current beat.
- `fb_wr_valid`  out  1  output beat valid.
- `fb_wr_ready`  in  1  downstream accepts beat.
- `clip_pulse`  out  NUM_CH  one-cycle pulse per discarded out-of-range write.
- `clip_count`  out  16  saturating total of discarded writes.

## Operation
- Accept on channel i when `ch_wr_en[i] & ch_ready[i]` at a rising edge. If `ch_wr_en` is asserted while not ready, the write is ignored: no queueing, no error, and no `clip_pulse`.
- `ch_ready[i]` = FIFO i count < FIFO_DEPTH, from registered count only. A full FIFO stays not-ready even in a cycle where it is popped.
- Clipping: an accepted write with x ≥ FB_WIDTH or y ≥ FB_HEIGHT is not enqueued. It pulses `clip_pulse[i]` the following cycle and increments `clip_count`. Simultaneous clips on k channels add k; `clip_count` saturates at 0xFFFF.
- Output register: loaded when `!fb_wr_valid | fb_wr_ready`. The source is the first non-empty FIFO after `last_grant`, searching cyclically. `last_grant` is updated to the loaded channel. If every FIFO is empty, `fb_wr_valid` drops to 0.
- Once valid, `fb_wr_addr`/`fb_wr_data`/`fb_wr_ch` stay stable until `fb_wr_ready` is sampled high.
- Address = y*FB_WIDTH + x, computed at full precision and truncated to ADDR_W.
- FIFOs: circular, pointers wrap modulo FIFO_DEPTH. Push and pop on the same FIFO in the same cycle are both legal and leave the count unchanged.
- Reset, asynchronous and active-low, including mid-transfer: all FIFOs empty and their contents discarded, `last_grant` = NUM_CH-1 (channel 0 first), `fb_wr_valid`=0, `fb_wr_addr`=0, `fb_wr_data`=0, `fb_wr_ch`=0, `clip_pulse`=0, `clip_count`=0, `ch_ready`=all 1.

## Timing
- Push at edge E into an empty system: `fb_wr_valid` high after edge E+1, a 1-cycle latency with no input bypass.
- Sustained throughput is one beat per cycle while `fb_wr_ready`=1 and any FIFO is non-empty.
- Fairness: with all channels continuously backlogged, grants rotate 0,1,…,NUM_CH-1,0. No channel waits more than NUM_CH-1 beats.
- `clip_pulse` is registered and asserted for exactly the cycle after the offending edge.

## Configuration
- `FB_WRITE_ARB_CLIP_EN` defined: bounds check and clipping as above.
- Not defined: no bounds check; every accepted write is enqueued, and the address truncates modulo 2^ADDR_W. `clip_pulse` and `clip_count` are tied to 0.

## Test plan
- Single write ch0 (x=5, y=2, value=0xABC), `fb_wr_ready`=1 → one beat 1 cycle later: addr 1285, data 0xABC, ch 0.
- NUM_CH=2, both channels write 4 pixels each on the same cycles, `fb_wr_ready`=1 → beats alternate ch0,ch1,… with per-channel order preserved; 8 beats total.
- Hold `fb_wr_ready`=0, ch0 writes 6 times → beat held stable; `ch_ready[0]` low after the FIFO fills; refused writes are lost; after release exactly FIFO_DEPTH+1 beats emerge.
- With CLIP_EN, write x=640, y=0 and x=0, y=480 → no beats, `clip_pulse[0]` pulses twice, `clip_count`=2. Without CLIP_EN → 2 beats at addr 640 and 307200.
- Assert reset low mid-stream with 3 entries queued → `fb_wr_valid`=0 immediately. After release, no stale beats appear and channel 0 wins first.
- Force 0x10000 clips → `clip_count` holds at 0xFFFF.

Source files
------------

// File: rtl/fb_write_arbiter.sv
// Multi-channel framebuffer write port: per-channel pixel FIFOs arbitrated round-robin onto one
// valid/ready write bus. Define FB_WRITE_ARB_CLIP_EN to discard and count out-of-range writes.
module fb_write_arbiter #(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned X_W        = 10,
    parameter int unsigned Y_W        = 10,
    parameter int unsigned PXL_W      = 12,
    parameter int unsigned FB_WIDTH   = 640,
    parameter int unsigned FB_HEIGHT  = 480,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_W     = 19,
    localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CH*X_W-1:0]     ch_pxl_x,
    input  logic [NUM_CH*Y_W-1:0]     ch_pxl_y,
    input  logic [NUM_CH*PXL_W-1:0]   ch_pxl_value,
    input  logic [NUM_CH-1:0]         ch_wr_en,
    output logic [NUM_CH-1:0]         ch_ready,
    output logic [ADDR_W-1:0]         fb_wr_addr,
    output logic [PXL_W-1:0]          fb_wr_data,
    output logic [CH_W-1:0]           fb_wr_ch,
    output logic                      fb_wr_valid,
    input  logic                      fb_wr_ready,
    output logic [NUM_CH-1:0]         clip_pulse,
    output logic [15:0]               clip_count
);

    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned ENTRY_W = ADDR_W + PXL_W;

    if (NUM_CH < 1 || NUM_CH > 8 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0
        || FB_WIDTH == 0 || FB_HEIGHT == 0) begin : g_param_check
        $error("fb_write_arbiter: illegal parameter set");
    end

    logic [ENTRY_W-1:0] mem_q    [NUM_CH][FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q [NUM_CH];
    logic [PTR_W-1:0]   rd_ptr_q [NUM_CH];
    logic [CNT_W-1:0]   count_q  [NUM_CH];

    logic [X_W-1:0]     px       [NUM_CH];
    logic [Y_W-1:0]     py       [NUM_CH];
    logic [PXL_W-1:0]   value    [NUM_CH];
    logic [ADDR_W-1:0]  lin_addr [NUM_CH];

    logic [NUM_CH-1:0]  accept;
    logic [NUM_CH-1:0]  clip;
    logic [NUM_CH-1:0]  push;
    logic [NUM_CH-1:0]  pop;
    logic [NUM_CH-1:0]  not_empty;

    logic [CH_W-1:0]    last_grant_q;
    logic [CH_W-1:0]    sel;
    logic [CH_W-1:0]    cand;
    logic               found;
    logic               load;
    logic [ENTRY_W-1:0] head;

    // Address math is done modulo 2^ADDR_W, which equals the truncated full-precision result.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            px[i]        = ch_pxl_x[i*X_W +: X_W];
            py[i]        = ch_pxl_y[i*Y_W +: Y_W];
            value[i]     = ch_pxl_value[i*PXL_W +: PXL_W];
            lin_addr[i]  = ADDR_W'(py[i]) * ADDR_W'(FB_WIDTH) + ADDR_W'(px[i]);
            ch_ready[i]  = count_q[i] != CNT_W'(FIFO_DEPTH);
            not_empty[i] = count_q[i] != '0;
            accept[i]    = ch_wr_en[i] & ch_ready[i];
`ifdef FB_WRITE_ARB_CLIP_EN
            clip[i]      = accept[i] & ((32'(px[i]) >= FB_WIDTH) | (32'(py[i]) >= FB_HEIGHT));
`else
            clip[i]      = 1'b0;
`endif
            push[i]      = accept[i] & ~clip[i];
        end
    end

    // Round-robin: first non-empty FIFO strictly after the last granted channel.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand = CH_W'((int'(last_grant_q) + k) % NUM_CH);
            if (!found && not_empty[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
        load = !fb_wr_valid | fb_wr_ready;
        pop  = '0;
        if (load && found) begin
            pop[sel] = 1'b1;
        end
        head = mem_q[sel][rd_ptr_q[sel]];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (push[i]) begin
                    wr_ptr_q[i] <= wr_ptr_q[i] + PTR_W'(1);
                end
                if (pop[i]) begin
                    rd_ptr_q[i] <= rd_ptr_q[i] + PTR_W'(1);
                end
                count_q[i] <= count_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
            end
        end
    end

    // Storage needs no reset: entries are only read behind a non-zero count.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (push[i]) begin
                mem_q[i][wr_ptr_q[i]] <= {lin_addr[i], value[i]};
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fb_wr_valid  <= 1'b0;
            fb_wr_addr   <= '0;
            fb_wr_data   <= '0;
            fb_wr_ch     <= '0;
            last_grant_q <= CH_W'(NUM_CH - 1);
        end else if (load) begin
            if (found) begin
                fb_wr_valid              <= 1'b1;
                {fb_wr_addr, fb_wr_data} <= head;
                fb_wr_ch                 <= sel;
                last_grant_q             <= sel;
            end else begin
                fb_wr_valid <= 1'b0;
            end
        end
    end

`ifdef FB_WRITE_ARB_CLIP_EN
    logic [NUM_CH-1:0] clip_pulse_q;
    logic [15:0]       clip_count_q;
    logic [16:0]       clip_sum;

    always_comb begin
        clip_sum = {1'b0, clip_count_q};
        for (int i = 0; i < NUM_CH; i++) begin
            clip_sum = clip_sum + 17'(clip[i]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clip_pulse_q <= '0;
            clip_count_q <= '0;
        end else begin
            clip_pulse_q <= clip;
            clip_count_q <= clip_sum[16] ? 16'hFFFF : clip_sum[15:0];
        end
    end

    assign clip_pulse = clip_pulse_q;
    assign clip_count = clip_count_q;
`else
    assign clip_pulse = '0;
    assign clip_count = '0;
`endif

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed self-checking bench for fb_write_arbiter (default parameters, NUM_CH=2).
module tb_fb_write_arbiter;

    localparam int unsigned NUM_CH = 2;
    localparam int unsigned X_W    = 10;
    localparam int unsigned Y_W    = 10;
    localparam int unsigned PXL_W  = 12;
    localparam int unsigned ADDR_W = 19;
    localparam int unsigned CH_W   = 1;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [NUM_CH*X_W-1:0]   ch_pxl_x;
    logic [NUM_CH*Y_W-1:0]   ch_pxl_y;
    logic [NUM_CH*PXL_W-1:0] ch_pxl_value;
    logic [NUM_CH-1:0]       ch_wr_en;
    logic [NUM_CH-1:0]       ch_ready;
    logic [ADDR_W-1:0]       fb_wr_addr;
    logic [PXL_W-1:0]        fb_wr_data;
    logic [CH_W-1:0]         fb_wr_ch;
    logic                    fb_wr_valid;
    logic                    fb_wr_ready;
    logic [NUM_CH-1:0]       clip_pulse;
    logic [15:0]             clip_count;

    int n_total = 0;
    int n_bad   = 0;
    int k;
    int exp_ch;
    int idx;

    fb_write_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .ch_pxl_x     (ch_pxl_x),
        .ch_pxl_y     (ch_pxl_y),
        .ch_pxl_value (ch_pxl_value),
        .ch_wr_en     (ch_wr_en),
        .ch_ready     (ch_ready),
        .fb_wr_addr   (fb_wr_addr),
        .fb_wr_data   (fb_wr_data),
        .fb_wr_ch     (fb_wr_ch),
        .fb_wr_valid  (fb_wr_valid),
        .fb_wr_ready  (fb_wr_ready),
        .clip_pulse   (clip_pulse),
        .clip_count   (clip_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input int x, input int y, input int v);
        ch_pxl_x[ch*X_W +: X_W]         = X_W'(x);
        ch_pxl_y[ch*Y_W +: Y_W]         = Y_W'(y);
        ch_pxl_value[ch*PXL_W +: PXL_W] = PXL_W'(v);
        ch_wr_en[ch]                    = 1'b1;
    endtask

    task automatic idle();
        ch_wr_en = '0;
    endtask

    task automatic do_reset();
        idle();
        fb_wr_ready = 1'b0;
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        reset        = 1'b0;
        ch_pxl_x     = '0;
        ch_pxl_y     = '0;
        ch_pxl_value = '0;
        ch_wr_en     = '0;
        fb_wr_ready  = 1'b0;

        // Reset state
        do_reset();
        check("rst_valid", 32'(fb_wr_valid), 0);
        check("rst_addr", 32'(fb_wr_addr), 0);
        check("rst_data", 32'(fb_wr_data), 0);
        check("rst_ch", 32'(fb_wr_ch), 0);
        check("rst_ready", 32'(ch_ready), 32'h3);
        check("rst_clip_pulse", 32'(clip_pulse), 0);
        check("rst_clip_count", 32'(clip_count), 0);

        // Single write, one-cycle latency
        fb_wr_ready = 1'b1;
        set_ch(0, 5, 2, 'hABC);
        tick();
        idle();
        check("lat_not_yet", 32'(fb_wr_valid), 0);
        tick();
        check("single_valid", 32'(fb_wr_valid), 1);
        check("single_addr", 32'(fb_wr_addr), 1285);
        check("single_data", 32'(fb_wr_data), 'hABC);
        check("single_ch", 32'(fb_wr_ch), 0);
        tick();
        check("single_done", 32'(fb_wr_valid), 0);

        // Both channels backlogged: alternating grants, back-to-back beats
        do_reset();
        fb_wr_ready = 1'b1;
        k = 0;
        for (int c = 0; c < 12; c++) begin
            if (c < 4) begin
                set_ch(0, c, 0, 'h100 + c);
                set_ch(1, c, 1, 'h200 + c);
            end else begin
                idle();
            end
            tick();
            if (fb_wr_valid) begin
                if (k < 8) begin
                    exp_ch = k % 2;
                    idx    = k / 2;
                    check("rr_slot", 32'(k), 32'(c - 1));
                    check("rr_ch", 32'(fb_wr_ch), 32'(exp_ch));
                    check("rr_addr", 32'(fb_wr_addr), 32'(exp_ch * 640 + idx));
                    check("rr_data", 32'(fb_wr_data), 32'((exp_ch == 1 ? 'h200 : 'h100) + idx));
                end
                k++;
            end
        end
        check("rr_beats", 32'(k), 8);

        // Backpressure: beat held, FIFO fills, extra write lost
        do_reset();
        for (int c = 0; c < 6; c++) begin
            set_ch(0, 10 + c, 3, 'h300 + c);
            tick();
            if (c >= 1) begin
                check("hold_valid", 32'(fb_wr_valid), 1);
                check("hold_addr", 32'(fb_wr_addr), 1930);
                check("hold_data", 32'(fb_wr_data), 'h300);
            end
            check("fill_ready", 32'(ch_ready), (c >= 4) ? 32'h2 : 32'h3);
        end
        idle();
        fb_wr_ready = 1'b1;
        check("rdy_while_pop", 32'(ch_ready), 32'h2);
        k = 0;
        for (int c = 0; c < 10; c++) begin
            if (fb_wr_valid) begin
                if (k < 5) begin
                    check("drain_addr", 32'(fb_wr_addr), 32'(1930 + k));
                    check("drain_data", 32'(fb_wr_data), 32'('h300 + k));
                end
                k++;
            end
            tick();
        end
        check("drain_beats", 32'(k), 5);
        check("drain_ready", 32'(ch_ready), 32'h3);

        // Out-of-range coordinates
        do_reset();
        fb_wr_ready = 1'b1;
        set_ch(0, 640, 0, 'h111);
        tick();
        set_ch(0, 0, 480, 'h222);
`ifdef FB_WRITE_ARB_CLIP_EN
        check("clip0_pulse", 32'(clip_pulse), 32'h1);
        check("clip0_count", 32'(clip_count), 1);
        tick();
        idle();
        check("clip1_pulse", 32'(clip_pulse), 32'h1);
        check("clip1_count", 32'(clip_count), 2);
        check("clip1_valid", 32'(fb_wr_valid), 0);
        tick();
        check("clip2_pulse", 32'(clip_pulse), 0);
        check("clip2_count", 32'(clip_count), 2);
        check("clip2_valid", 32'(fb_wr_valid), 0);
        tick();
        check("clip3_valid", 32'(fb_wr_valid), 0);
`else
        check("oob0_valid", 32'(fb_wr_valid), 0);
        tick();
        idle();
        check("oob1_valid", 32'(fb_wr_valid), 1);
        check("oob1_addr", 32'(fb_wr_addr), 640);
        check("oob1_data", 32'(fb_wr_data), 'h111);
        tick();
        check("oob2_valid", 32'(fb_wr_valid), 1);
        check("oob2_addr", 32'(fb_wr_addr), 307200);
        check("oob2_data", 32'(fb_wr_data), 'h222);
        check("oob_clip_pulse", 32'(clip_pulse), 0);
        check("oob_clip_count", 32'(clip_count), 0);
        tick();
        check("oob3_valid", 32'(fb_wr_valid), 0);
        // 1023*640+1023 = 655743, modulo 2^19 = 131455
        set_ch(1, 1023, 1023, 'h7E7);
        tick();
        idle();
        tick();
        check("trunc_valid", 32'(fb_wr_valid), 1);
        check("trunc_addr", 32'(fb_wr_addr), 131455);
        check("trunc_ch", 32'(fb_wr_ch), 1);
        tick();
`endif

        // Reset mid-stream with three entries queued behind the output register
        do_reset();
        for (int c = 0; c < 4; c++) begin
            set_ch(0, c, 5, 'h400 + c);
            tick();
        end
        idle();
        check("pre_rst_valid", 32'(fb_wr_valid), 1);
        check("pre_rst_addr", 32'(fb_wr_addr), 3200);
        #2;
        reset = 1'b0;
        #1;
        check("async_valid", 32'(fb_wr_valid), 0);
        check("async_addr", 32'(fb_wr_addr), 0);
        check("async_data", 32'(fb_wr_data), 0);
        check("async_ready", 32'(ch_ready), 32'h3);
        tick();
        tick();
        reset = 1'b1;
        fb_wr_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("no_stale", 32'(fb_wr_valid), 0);
        end
        set_ch(0, 7, 0, 'h500);
        set_ch(1, 8, 0, 'h600);
        tick();
        idle();
        tick();
        check("post_rst_ch0", 32'(fb_wr_ch), 0);
        check("post_rst_addr0", 32'(fb_wr_addr), 7);
        check("post_rst_data0", 32'(fb_wr_data), 'h500);
        tick();
        check("post_rst_ch1", 32'(fb_wr_ch), 1);
        check("post_rst_addr1", 32'(fb_wr_addr), 8);
        check("post_rst_data1", 32'(fb_wr_data), 'h600);
        tick();
        check("post_rst_idle", 32'(fb_wr_valid), 0);

`ifdef FB_WRITE_ARB_CLIP_EN
        // Saturation: two clips per cycle
        do_reset();
        set_ch(0, 640, 0, 0);
        set_ch(1, 0, 480, 0);
        for (int c = 0; c < 32767; c++) begin
            tick();
        end
        check("sat_below", 32'(clip_count), 32'hFFFE);
        tick();
        check("sat_hit", 32'(clip_count), 32'hFFFF);
        tick();
        check("sat_hold", 32'(clip_count), 32'hFFFF);
        check("sat_pulse", 32'(clip_pulse), 32'h3);
        check("sat_valid", 32'(fb_wr_valid), 0);
        idle();
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
